mult_div_unit: RTL and testbench

- E-stage multiply/divide unit with architectural HI/LO registers for the P6 five-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage. Exposes HI/LO to the E-stage result mux for MFHI/MFLO.
- Drives Start/Busy to the hazard controller, which stalls any D-stage HI/LO-touching instruction while Start|Busy.

---
 rtl/mult_div_unit_pkg.sv | 22 ++
 rtl/mult_div_unit_md_arith.sv | 57 +++++
 rtl/mult_div_unit.sv | 116 +++++++++++
 tb/tb_mult_div_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MD_Op encodings and default latencies for the multiply/divide unit.
// The decoder and hazard controller import the same encodings.
package mult_div_unit_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6
   } md_op_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational 64-bit MULT/MULTU/DIV/DIVU result ({HI, LO}) plus divide-by-zero flag.
// A single unsigned divider serves both divides; signed DIV runs on magnitudes.
module md_arith
   import mult_div_unit_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_result,
   output logic        o_div_zero
);

   logic [63:0] w_smul;
   logic [63:0] w_umul;
   logic        w_is_div;
   logic        w_is_sdiv;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_dividend;
   logic [31:0] w_divisor;
   logic [31:0] w_q;
   logic [31:0] w_r;
   logic [31:0] w_sq;
   logic [31:0] w_sr;

   assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
   assign w_umul = {32'd0, i_a} * {32'd0, i_b};

   assign w_is_sdiv  = (i_op == MD_DIV);
   assign w_is_div   = w_is_sdiv || (i_op == MD_DIVU);
   assign o_div_zero = w_is_div && (i_b == 32'd0);

   assign w_a_mag = i_a[31] ? (~i_a + 32'd1) : i_a;
   assign w_b_mag = i_b[31] ? (~i_b + 32'd1) : i_b;

   // Divisor forced to 1 on zero so the divider never sees x/0; result is discarded.
   assign w_dividend = w_is_sdiv ? w_a_mag : i_a;
   assign w_divisor  = (i_b == 32'd0) ? 32'd1 : (w_is_sdiv ? w_b_mag : i_b);
   assign w_q        = w_dividend / w_divisor;
   assign w_r        = w_dividend % w_divisor;

   // 0x80000000 / -1 wraps to 0x80000000 naturally through the negation.
   assign w_sq = (i_a[31] ^ i_b[31]) ? (~w_q + 32'd1) : w_q;
   assign w_sr = i_a[31] ? (~w_r + 32'd1) : w_r;

   always_comb begin
      o_result = 64'd0;
      case (i_op)
         MD_MULT:  o_result = w_smul;
         MD_MULTU: o_result = w_umul;
         MD_DIV:   o_result = {w_sr, w_sq};
         MD_DIVU:  o_result = {w_r, w_q};
         default:  o_result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy down-counter, pending result.
// Optional MDU_CANCEL_EN adds a Cancel input that flushes an in-flight op without commit.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MD_Op,
   input  logic        Start,
   input  logic [31:0] A,
   input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
   input  logic        Cancel,
`endif
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

   logic [63:0]      w_result;
   logic             w_div_zero;
   logic             w_cancel;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_is_div;
   logic             w_commit;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_pend_hi;
   logic [31:0]      r_pend_lo;
   logic             r_pend_ok;

   md_arith u_arith (
      .i_op       (MD_Op),
      .i_a        (A),
      .i_b        (B),
      .o_result   (w_result),
      .o_div_zero (w_div_zero)
   );

`ifdef MDU_CANCEL_EN
   assign w_cancel = Cancel;
`else
   assign w_cancel = 1'b0;
`endif

   assign w_accept = Start && !r_busy && !w_cancel && (MD_Op != MD_NONE);
   assign w_is_mul = (MD_Op == MD_MULT) || (MD_Op == MD_MULTU);
   assign w_is_div = (MD_Op == MD_DIV) || (MD_Op == MD_DIVU);
   assign w_commit = !w_cancel && (r_cnt == CNT_W'(1)) && r_pend_ok;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_cancel)
         w_cnt_nxt = '0;
      else if (w_accept && w_is_mul)
         w_cnt_nxt = CNT_W'(MULT_CYCLES);
      else if (w_accept && w_is_div)
         w_cnt_nxt = CNT_W'(DIV_CYCLES);
      else if (r_cnt != '0)
         w_cnt_nxt = r_cnt - CNT_W'(1);
   end

   // Busy is registered alongside the counter so the output has no input-to-output path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_busy <= (w_cnt_nxt != '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_ok <= 1'b0;
      end else if (w_accept && (w_is_mul || w_is_div)) begin
         r_pend_hi <= w_result[63:32];
         r_pend_lo <= w_result[31:0];
         r_pend_ok <= !w_div_zero;
      end else if (w_cancel) begin
         r_pend_ok <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_accept && (MD_Op == MD_MTHI)) begin
         r_hi <= A;
      end else if (w_accept && (MD_Op == MD_MTLO)) begin
         r_lo <= A;
      end else if (w_commit) begin
         r_hi <= r_pend_hi;
         r_lo <= r_pend_lo;
      end
   end

   assign Busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default latencies 5/10).
// Cancel scenarios are compiled in when MDU_CANCEL_EN is defined.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  MD_Op;
   logic        Start;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
`ifdef MDU_CANCEL_EN
   logic        Cancel;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .MD_Op (MD_Op),
      .Start (Start),
      .A     (A),
      .B     (B),
`ifdef MDU_CANCEL_EN
      .Cancel(Cancel),
`endif
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      MD_Op = op; A = a; B = b; Start = 1'b1;
      step();
      Start = 1'b0; MD_Op = MD_NONE;
   endtask

   task automatic test_reset();
      reset = 1'b0; Start = 1'b0; MD_Op = MD_NONE; A = '0; B = '0;
`ifdef MDU_CANCEL_EN
      Cancel = 1'b0;
`endif
      step(); step();
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL reset_hold: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
      end
      reset = 1'b1;
      step(); step();
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL reset_idle: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
      end
   endtask

   task automatic test_mult();
      logic [3:0]  ops [2] = '{MD_MULT, MD_MULTU};
      logic [31:0] t_hi[2] = '{32'hFFFFFFFF, 32'h00000001};
      logic [31:0] t_lo[2] = '{32'hFFFFFFFE, 32'hFFFFFFFE};
      for (int i = 0; i < 2; i++) begin
         issue(ops[i], 32'hFFFFFFFF, 32'd2);
         for (int c = 1; c <= 5; c++) begin
            checks++;
            if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
               errors++;
               $display("FAIL mult_busy op%0d cyc%0d: Busy=%b HI=%h LO=%h want 1/%h/%h",
                        i, c, Busy, HI, LO, exp_hi, exp_lo);
            end
            step();
         end
         exp_hi = t_hi[i]; exp_lo = t_lo[i];
         checks++;
         if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL mult_result op%0d: Busy=%b HI=%h LO=%h want 0/%h/%h",
                     i, Busy, HI, LO, exp_hi, exp_lo);
         end
      end
   endtask

   task automatic test_div();
      logic [3:0]  ops [3] = '{MD_DIV, MD_DIVU, MD_DIV};
      logic [31:0] t_a [3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
      logic [31:0] t_b [3] = '{32'd2, 32'd2, 32'hFFFFFFFF};
      logic [31:0] t_hi[3] = '{32'hFFFFFFFF, 32'd1, 32'd0};
      logic [31:0] t_lo[3] = '{32'hFFFFFFFD, 32'd3, 32'h80000000};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], t_a[i], t_b[i]);
         for (int c = 1; c <= 10; c++) begin
            checks++;
            if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
               errors++;
               $display("FAIL div_busy op%0d cyc%0d: Busy=%b HI=%h LO=%h want 1/%h/%h",
                        i, c, Busy, HI, LO, exp_hi, exp_lo);
            end
            step();
         end
         exp_hi = t_hi[i]; exp_lo = t_lo[i];
         checks++;
         if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL div_result op%0d: Busy=%b HI=%h LO=%h want 0/%h/%h",
                     i, Busy, HI, LO, exp_hi, exp_lo);
         end
      end
   endtask

   task automatic test_mthi_mtlo();
      MD_Op = MD_MTHI; A = 32'h12345678; Start = 1'b1;
      step();
      exp_hi = 32'h12345678;
      checks++;
      if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         errors++;
         $display("FAIL mthi: Busy=%b HI=%h LO=%h want 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
      end
      MD_Op = MD_MTLO; A = 32'h9ABCDEF0;
      step();
      Start = 1'b0; MD_Op = MD_NONE;
      exp_lo = 32'h9ABCDEF0;
      checks++;
      if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         errors++;
         $display("FAIL mtlo: Busy=%b HI=%h LO=%h want 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
      end
      step();
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL mtlo_idle: Busy=%b want 0", Busy);
      end
   endtask

   task automatic test_div_zero();
      issue(MD_DIVU, 32'd55, 32'd0);
      for (int c = 1; c <= 10; c++) begin
         checks++;
         if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL divzero_busy cyc%0d: Busy=%b HI=%h LO=%h want 1/%h/%h",
                     c, Busy, HI, LO, exp_hi, exp_lo);
         end
         step();
      end
      step();
      checks++;
      if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         errors++;
         $display("FAIL divzero_result: Busy=%b HI=%h LO=%h want 0/%h/%h",
                  Busy, HI, LO, exp_hi, exp_lo);
      end
   endtask

   task automatic test_busy_ignore();
      issue(MD_MULT, 32'd3, 32'd5);
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL ignore_busy cyc%0d: Busy=%b HI=%h LO=%h want 1/%h/%h",
                     c, Busy, HI, LO, exp_hi, exp_lo);
         end
         if (c == 2) begin
            MD_Op = MD_MULT; A = 32'd7; B = 32'd7; Start = 1'b1;
         end
         step();
         Start = 1'b0; MD_Op = MD_NONE;
      end
      exp_hi = 32'd0; exp_lo = 32'd15;
      checks++;
      if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         errors++;
         $display("FAIL ignore_result: Busy=%b HI=%h LO=%h want 0/%h/%h",
                  Busy, HI, LO, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset_mid();
      issue(MD_DIV, 32'd100, 32'd7);
      step(); step();
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: Busy=%b want 1", Busy);
      end
      reset = 1'b0;
      #1;
      exp_hi = 32'd0; exp_lo = 32'd0;
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_async: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
      end
      step(); step();
      reset = 1'b1;
      for (int c = 0; c < 12; c++) step();
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_after: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
      end
   endtask

`ifdef MDU_CANCEL_EN
   task automatic test_cancel();
      issue(MD_MTHI, 32'hA5A50001, 32'd0);
      issue(MD_MTLO, 32'h5A5A0002, 32'd0);
      exp_hi = 32'hA5A50001; exp_lo = 32'h5A5A0002;
      issue(MD_MULT, 32'h10, 32'h10);
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_busy cyc%0d: Busy=%b want 1", c, Busy);
         end
         if (c == 3) Cancel = 1'b1;
         step();
         Cancel = 1'b0;
      end
      checks++;
      if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         errors++;
         $display("FAIL cancel_flush: Busy=%b HI=%h LO=%h want 0/%h/%h",
                  Busy, HI, LO, exp_hi, exp_lo);
      end
      for (int c = 0; c < 5; c++) step();
      checks++;
      if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         errors++;
         $display("FAIL cancel_nocommit: Busy=%b HI=%h LO=%h want 0/%h/%h",
                  Busy, HI, LO, exp_hi, exp_lo);
      end
      MD_Op = MD_MTLO; A = 32'hDEADBEEF; Start = 1'b1; Cancel = 1'b1;
      step();
      Start = 1'b0; MD_Op = MD_NONE; Cancel = 1'b0;
      checks++;
      if (Busy !== 1'b0 || LO !== exp_lo) begin
         errors++;
         $display("FAIL cancel_mtlo: Busy=%b LO=%h want 0/%h", Busy, LO, exp_lo);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_div_zero();
      test_busy_ignore();
      test_reset_mid();
`ifdef MDU_CANCEL_EN
      test_cancel();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
